// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin pop scheduler.
package wrr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int QUEUE_QUANTITY_DFLT = 4;
    localparam int MAX_WEIGHT_DFLT     = 64;
    localparam int SEL_W               = $clog2(QUEUE_QUANTITY_DFLT);
    localparam int W_W                 = $clog2(MAX_WEIGHT_DFLT);

    // Upper bounds of the generic weight extractor below.
    localparam int PESOS_MAX_W  = 1024;
    localparam int WEIGHT_MAX_W = 16;

    // Extract weight idx (w_w bits wide) from a zero-extended packed pesos bus.
    function automatic logic [WEIGHT_MAX_W-1:0] weight_of(
        input logic [PESOS_MAX_W-1:0] pesos,
        input int unsigned            idx,
        input int unsigned            w_w
    );
        logic [PESOS_MAX_W-1:0] shifted;
        logic [31:0]            mask;
        shifted = pesos >> (idx * w_w);
        mask    = (32'd1 << w_w) - 32'd1;
        return shifted[WEIGHT_MAX_W-1:0] & mask[WEIGHT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/next_queue_finder.sv
// Rotating-priority search: first eligible queue after ptr, wrapping back to ptr itself.
module next_queue_finder #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] next_idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest eligible queue wins;
    // offset N wraps to ptr itself, giving it the lowest priority.
    always_comb begin
        found    = 1'b0;
        next_idx = ptr;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (eligible[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop controller draining the per-class FIFOs into one egress path.
//
// state | meaning
// IDLE  | no queue being served; waiting for an eligible queue and no back-pressure
// SERVE | popping queue ptr, credit pops left in its current turn
module wrr_pop_scheduler
    import wrr_pkg::*;
#(
    parameter  int QUEUE_QUANTITY = 4,
    parameter  int MAX_WEIGHT     = 64,
    localparam int QSEL_W         = $clog2(QUEUE_QUANTITY),
    localparam int WGT_W          = $clog2(MAX_WEIGHT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enb,
    input  logic [QUEUE_QUANTITY*WGT_W-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]       buf_empty,
    input  logic                            dest_full,
    output logic [QUEUE_QUANTITY-1:0]       pop,
    output logic [QSEL_W-1:0]               selector,
    output logic                            selector_enb,
    output logic                            valid_out,
    output logic [QSEL_W-1:0]               valid_sel
);

    state_t              state, state_n;
    logic [QSEL_W-1:0]   ptr, ptr_n;
    logic [WGT_W-1:0]    credit, credit_n;
    logic [WGT_W-1:0]    weight [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic                found;
    logic [QSEL_W-1:0]   nxt;

    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_weight
        assign weight[i]   = WGT_W'(weight_of(PESOS_MAX_W'(pesos), i, WGT_W));
        assign eligible[i] = !buf_empty[i] && (weight[i] != '0);
    end

    next_queue_finder #(
        .N (QUEUE_QUANTITY)
    ) u_finder (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .next_idx (nxt)
    );

    // Next-state and pop decode; a turn ending (credit exhausted or FIFO ran dry)
    // rotates in the same cycle so the next queue is served without a bubble.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        credit_n = credit;
        pop      = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (enb && !dest_full && found) begin
                        state_n  = SERVE;
                        ptr_n    = nxt;
                        credit_n = weight[nxt];
                    end
                end
                SERVE: begin
                    if (enb && !dest_full) begin
                        if (buf_empty[ptr]) begin
                            if (found) begin
                                ptr_n    = nxt;
                                credit_n = weight[nxt];
                            end else begin
                                state_n  = IDLE;
                            end
                        end else begin
                            pop[ptr] = 1'b1;
                            if (credit == WGT_W'(1)) begin
                                if (found) begin
                                    ptr_n    = nxt;
                                    credit_n = weight[nxt];
                                end else begin
                                    state_n  = IDLE;
                                end
                            end else begin
                                credit_n = credit - WGT_W'(1);
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Scheduler state register; enb=0 holds because the decode above holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            credit <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            credit <= credit_n;
        end
    end

    // Data-valid strobe and its selector, aligned with FIFO read data at the mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            valid_sel <= '0;
        end else if (enb) begin
            valid_out <= |pop;
            valid_sel <= ptr;
        end else begin
            valid_out <= 1'b0;
            valid_sel <= '0;
        end
    end

    assign selector     = ptr;
    assign selector_enb = |pop;

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Self-checking bench for wrr_pop_scheduler: directed scenarios plus random traffic,
// every cycle compared against a turn-based reference model.
module tb_wrr_pop_scheduler;

    localparam int Q  = 4;
    localparam int WW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic [Q*WW-1:0] pesos;
    logic [Q-1:0]  buf_empty;
    logic          dest_full;
    logic [Q-1:0]  pop;
    logic [1:0]    selector;
    logic          selector_enb;
    logic          valid_out;
    logic [1:0]    valid_sel;

    wrr_pop_scheduler #(
        .QUEUE_QUANTITY (Q),
        .MAX_WEIGHT     (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .dest_full    (dest_full),
        .pop          (pop),
        .selector     (selector),
        .selector_enb (selector_enb),
        .valid_out    (valid_out),
        .valid_sel    (valid_sel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tw [Q];
    int trace [$];

    // Reference model: "a turn is in progress for queue m_q with m_left pops left".
    bit m_busy = 0;
    int m_q    = 0;
    int m_left = 0;
    int m_vout = 0;
    int m_vsel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        tw[0] = w0; tw[1] = w1; tw[2] = w2; tw[3] = w3;
        for (int i = 0; i < Q; i++) pesos[i*WW +: WW] = WW'(tw[i]);
    endtask

    function automatic int find_next(input int p);
        for (int k = 1; k <= Q; k++) begin
            int c;
            c = (p + k) % Q;
            if (!buf_empty[c] && tw[c] != 0) return c;
        end
        return -1;
    endfunction

    function automatic int exp_pop();
        if (rst || !m_busy || !enb || dest_full || buf_empty[m_q]) return -1;
        return m_q;
    endfunction

    task automatic start_turn();
        int n;
        n = find_next(m_q);
        if (n < 0) begin
            m_busy = 0;
        end else begin
            m_busy = 1;
            m_q    = n;
            m_left = tw[n];
        end
    endtask

    task automatic model_update(input int ep);
        if (rst) begin
            m_busy = 0; m_q = 0; m_left = 0; m_vout = 0; m_vsel = 0;
            return;
        end
        if (enb) begin
            m_vout = (ep >= 0) ? 1 : 0;
            m_vsel = m_q;
        end else begin
            m_vout = 0;
            m_vsel = 0;
        end
        if (!enb || dest_full) return;
        if (!m_busy) begin
            if (find_next(m_q) >= 0) start_turn();
        end else if (ep < 0) begin
            start_turn();
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) start_turn();
        end
    endtask

    task automatic cycle();
        int         ep;
        logic [3:0] epv;
        ep  = exp_pop();
        epv = (ep >= 0) ? 4'(1 << ep) : 4'd0;
        #1;
        chk("pop", 32'(pop), 32'(epv));
        chk("selector_enb", 32'(selector_enb), (ep >= 0) ? 32'd1 : 32'd0);
        chk("selector", 32'(selector), 32'(m_q));
        chk("valid_out", 32'(valid_out), 32'(m_vout));
        chk("valid_sel", 32'(valid_sel), 32'(m_vsel));
        if (selector_enb) trace.push_back(int'(selector));
        @(posedge clk);
        model_update(ep);
        @(negedge clk);
    endtask

    task automatic run_until_pop(input int q, input int budget);
        int n0;
        for (int c = 0; c < budget; c++) begin
            n0 = trace.size();
            cycle();
            if (trace.size() > n0 && trace[$] == q) return;
        end
        checks++;
        errors++;
        $error("FAIL wait_pop_q%0d: no pop within %0d cycles", q, budget);
    endtask

    int pat1 [10] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
    int pat3 [6]  = '{2, 2, 3, 3, 0, 0};

    initial begin
        int n;
        int seen2;
        rst = 1'b1; enb = 1'b1; dest_full = 1'b0; buf_empty = '0;
        set_w(1, 2, 3, 4);
        @(posedge clk);
        @(negedge clk);

        // Weights 1..4, all full: steady rotation with period 10, no idle cycles.
        cycle();
        rst = 1'b0;
        trace.delete();
        repeat (21) cycle();
        chk("seq1_len", 32'(trace.size()), 32'd20);
        for (int i = 0; i < 20 && i < trace.size(); i++)
            chk("seq1", 32'(trace[i]), 32'(pat1[i % 10]));

        // q2 runs dry after its first pop: early rotation, later rejoin.
        run_until_pop(2, 20);
        buf_empty = 4'b0100;
        repeat (6) cycle();
        buf_empty = 4'b0000;
        trace.delete();
        repeat (12) cycle();
        seen2 = 0;
        foreach (trace[i]) if (trace[i] == 2) seen2 = 1;
        chk("q2_rejoins", 32'(seen2), 32'd1);

        // Weight 0 on q1: never served.
        rst = 1'b1;
        set_w(2, 0, 2, 2);
        cycle();
        rst = 1'b0;
        trace.delete();
        repeat (13) cycle();
        chk("seq3_len", 32'(trace.size()), 32'd12);
        for (int i = 0; i < 12 && i < trace.size(); i++)
            chk("seq3", 32'(trace[i]), 32'(pat3[i % 6]));

        // Back-pressure in the middle of q3's burst.
        rst = 1'b1;
        set_w(1, 2, 3, 4);
        cycle();
        rst = 1'b0;
        run_until_pop(3, 30);
        dest_full = 1'b1;
        n = trace.size();
        repeat (3) cycle();
        chk("stall_no_pop", 32'(trace.size()), 32'(n));
        dest_full = 1'b0;
        trace.delete();
        repeat (4) cycle();
        chk("stall_resume_len", 32'(trace.size()), 32'd4);
        if (trace.size() == 4) begin
            chk("stall_resume_q3a", 32'(trace[0]), 32'd3);
            chk("stall_resume_q3c", 32'(trace[2]), 32'd3);
            chk("stall_resume_q0", 32'(trace[3]), 32'd0);
        end

        // Everything empty, then only q1 refills.
        buf_empty = 4'b1111;
        repeat (4) cycle();
        buf_empty = 4'b1101;
        trace.delete();
        repeat (10) cycle();
        chk("only_q1_len", 32'(trace.size()), 32'd9);
        foreach (trace[i]) chk("only_q1", 32'(trace[i]), 32'd1);

        // Reset pulse in the middle of q2's burst.
        buf_empty = 4'b0000;
        run_until_pop(2, 20);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_selector", 32'(selector), 32'd0);
        trace.delete();
        repeat (3) cycle();
        chk("rst_first_len", 32'(trace.size()), 32'd2);
        if (trace.size() == 2) begin
            chk("rst_first_q1a", 32'(trace[0]), 32'd1);
            chk("rst_first_q1b", 32'(trace[1]), 32'd1);
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            enb       = ($urandom_range(0, 9) != 0);
            dest_full = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < Q; i++) buf_empty[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0)
                set_w($urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
